clb_chain_loader: RTL
=====================

Name: clb_chain_loader

Overview:
- Configuration controller that drives the serial programming chain of daisy-chained CLBs.
- Chain wiring: each CLB's prog_out feeds the next CLB's prog_in; the last CLB's prog_out returns to this block as chain_out.
- Accepts the bitstream as bytes over a valid/ready stream and shifts it out one bit per enabled clock.
- Optionally runs a non-destructive readback pass that rotates the chain once and compares CRC-8 signatures of the written and read-back streams.

Parameters:
- NUM_CLBS, 4, number of CLBs in the chain.
- CLB_BITS, 17, configuration bits per CLB.
- CHAIN_LEN, NUM_CLBS*CLB_BITS, total chain length in bits (derived, not overridden).

Ports:
- prog_clk  in  1  single clock. Shared with the CLB prog_clk.
- prog_rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load. Sampled only in IDLE.
- verify_en  in  1  request a readback pass. Sampled with start.
- s_data  in  8  bitstream byte, sent LSB first.
- s_valid  in  1  s_data valid.
- s_ready  out  1  byte accepted when s_valid && s_ready at a posedge.
- prog_in  out  1  serial data to the first CLB.
- prog_en  out  1  shift enable to all CLBs.
- chain_out  in  1  prog_out of the last CLB.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at the end of a load.
- verify_ok  out  1  readback CRC matched. Held until the next accepted start.
- verify_err  out  1  readback CRC mismatched. Held until the next accepted start.

Behaviour:
- Reset (asynchronous): state=IDLE. All counters, CRCs and byte_reg cleared. s_ready, prog_en, prog_in, busy, done, verify_ok and verify_err all 0.
- States: IDLE, FETCH, SHIFT, VERIFY, DONE.
- IDLE:
  - start=1 at a posedge -> FETCH.
  - Latch verify_en; clear bit_total, both CRCs, verify_ok and verify_err.
  - start while busy is ignored.
- FETCH:
  - s_ready=1, prog_en=0.
  - On handshake: byte_reg<=s_data, bit_idx<=0, go to SHIFT.
  - If s_valid stays low, remain in FETCH indefinitely; the chain does not shift.
- SHIFT:
  - prog_en=1 and prog_in=byte_reg[bit_idx]. These are combinational from registers, so no glitch at the state boundary.
  - Each posedge: bit_idx++, bit_total++, crc_wr updated with the bit.
  - Exit after bit_idx==7, or after bit_total reaches CHAIN_LEN, whichever comes first.
  - Exit target: bit_total==CHAIN_LEN goes to VERIFY (verify latched) or DONE (verify not latched); otherwise back to FETCH.
- Byte count: ceil(CHAIN_LEN/8). Unused upper bits of the final byte are discarded and not shifted. s_ready never rises after the final byte.
- Bit placement: stream bit k ends in chain position k, counted from chain_out. Bit 0 therefore lands in the last CLB's shift_reg[0].
- VERIFY:
  - prog_en=1 and prog_in=chain_out (combinational recirculation).
  - Runs exactly CHAIN_LEN cycles; each posedge folds chain_out into crc_rd.
  - After CHAIN_LEN cycles the chain contents equal the pre-verify contents. Bits emerge in the same order they were written.
- CRC-8 (used for both crc_wr and crc_rd): polynomial 0x07, init 0x00, bit-serial, unreflected. fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?8'h07:8'h00).
- DONE:
  - done=1 for one cycle, then IDLE.
  - If verify was latched: verify_ok=(crc_wr==crc_rd), verify_err=!verify_ok, both registered on entry to IDLE. Otherwise both stay 0.
- Latency with s_valid held high, no verify: ceil(CHAIN_LEN/8) FETCH cycles + CHAIN_LEN SHIFT cycles + 1 DONE cycle. For the defaults: 9+68+1=78 cycles from the first FETCH cycle to the done pulse. Verify adds CHAIN_LEN cycles (68).
- Reset mid-operation: prog_en drops immediately (asynchronous). Chain contents are undefined; the host must reload.
- s_valid in IDLE, SHIFT, VERIFY or DONE is ignored (s_ready=0).

Test Plan:
- NUM_CLBS=1, bytes 0xA5,0x3C,0x01, verify off, s_valid always high -> CLB shift_reg==17'h13CA5. done pulses 3+17+1=21 cycles after the first FETCH cycle. prog_en high exactly 17 cycles.
- Defaults with real CLB models, 9 random bytes, verify on -> verify_ok=1, verify_err=0. All CLB shift_regs unchanged across VERIFY. Total 146 cycles to done.
- Same as above but chain_out forced to 0 during VERIFY, with a bitstream whose crc_wr!=0 -> verify_err=1, verify_ok=0.
- Throttled input: s_valid low 5 cycles before each byte -> prog_en low during every stall. Final chain contents identical to the unthrottled run.
- Assert prog_rst during the 3rd SHIFT cycle of byte 2 -> prog_en, s_ready and busy go 0 without waiting for a clock edge. A subsequent full load yields correct contents and done.
- start pulsed while busy, and final byte 0xFF with NUM_CLBS=4 -> second start has no effect. Exactly 68 prog_en cycles occur, and the discarded upper 4 bits never reach the chain.

Source files
------------

// File: rtl/clb_chain_loader.sv
// Serial configuration loader for a daisy chain of CLBs: streams bytes out LSB first,
// then optionally recirculates the chain once and compares CRC-8 signatures.
module clb_chain_loader #(
    parameter int  NUM_CLBS  = 4,
    parameter int  CLB_BITS  = 17,
    localparam int CHAIN_LEN = NUM_CLBS * CLB_BITS
) (
    input  logic       prog_clk,
    input  logic       prog_rst,
    input  logic       start,
    input  logic       verify_en,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       prog_in,
    output logic       prog_en,
    input  logic       chain_out,
    output logic       busy,
    output logic       done,
    output logic       verify_ok,
    output logic       verify_err
);

    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | s_ready high, waiting for the next bitstream byte
    // SHIFT  | shifting byte_reg out, one bit per clock
    // VERIFY | chain recirculating through prog_in, folding chain_out into crc_rd
    // DONE   | one-cycle done pulse, verify result registered on exit

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] VFY_LEN  = CNT_W'(CHAIN_LEN);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        VERIFY,
        DONE
    } state_t;

    state_t           state;
    logic [7:0]       byte_reg;
    logic [2:0]       bit_idx;
    logic [CNT_W-1:0] bit_total;
    logic [CNT_W-1:0] vfy_cnt;
    logic [7:0]       crc_wr;
    logic [7:0]       crc_rd;
    logic             verify_lat;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // Decoded straight from registers so prog_en/prog_in cannot glitch between states
    // and drop the moment the asynchronous reset hits the state register.
    assign s_ready = (state == FETCH);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign prog_en = (state == SHIFT) || (state == VERIFY);
    assign prog_in = (state == SHIFT)  ? byte_reg[bit_idx] :
                     (state == VERIFY) ? chain_out : 1'b0;

    always_ff @(posedge prog_clk or posedge prog_rst) begin
        if (prog_rst) begin
            state      <= IDLE;
            byte_reg   <= '0;
            bit_idx    <= '0;
            bit_total  <= '0;
            vfy_cnt    <= '0;
            crc_wr     <= '0;
            crc_rd     <= '0;
            verify_lat <= 1'b0;
            verify_ok  <= 1'b0;
            verify_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FETCH;
                        verify_lat <= verify_en;
                        bit_total  <= '0;
                        crc_wr     <= '0;
                        crc_rd     <= '0;
                        verify_ok  <= 1'b0;
                        verify_err <= 1'b0;
                    end
                end
                FETCH: begin
                    if (s_valid) begin
                        byte_reg <= s_data;
                        bit_idx  <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_idx   <= bit_idx + 3'd1;
                    bit_total <= bit_total + CNT_W'(1);
                    crc_wr    <= crc8_step(crc_wr, byte_reg[bit_idx]);
                    // Final chain bit wins over the byte boundary; spare bits of the last byte are dropped.
                    if (bit_total == LAST_BIT) begin
                        state   <= verify_lat ? VERIFY : DONE;
                        vfy_cnt <= VFY_LEN;
                    end else if (bit_idx == 3'd7) begin
                        state <= FETCH;
                    end
                end
                VERIFY: begin
                    crc_rd  <= crc8_step(crc_rd, chain_out);
                    vfy_cnt <= vfy_cnt - CNT_W'(1);
                    if (vfy_cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (verify_lat) begin
                        verify_ok  <= (crc_wr == crc_rd);
                        verify_err <= (crc_wr != crc_rd);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
